// File: rtl/dbg_text_renderer_pkg.sv
// Shared constants, sideband type and the glyph table for the debug text overlay.
package dbg_text_renderer_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    // Row code driven during blanking; the character source answers 0 there.
    localparam logic [4:0] BLANK_ROW = 5'd31;

    localparam logic [23:0] DEF_FG = 24'hFFFFFF;
    localparam logic [23:0] DEF_BG = 24'h000080;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sideband_t;

    // 5x7 master glyphs for 0x20..0x5F, rows top to bottom, 5 bits per row,
    // MSB of each row is the leftmost pixel.
    function automatic logic [34:0] glyph5x7(input logic [6:0] code);
        logic [34:0] g;
        g = '0;
        case (code)
            7'h21: g = 35'b00100_00100_00100_00100_00100_00000_00100;
            7'h22: g = 35'b01010_01010_01010_00000_00000_00000_00000;
            7'h23: g = 35'b01010_01010_11111_01010_11111_01010_01010;
            7'h24: g = 35'b00100_01111_10100_01110_00101_11110_00100;
            7'h25: g = 35'b11000_11001_00010_00100_01000_10011_00011;
            7'h26: g = 35'b01100_10010_10100_01000_10101_10010_01101;
            7'h27: g = 35'b01100_00100_01000_00000_00000_00000_00000;
            7'h28: g = 35'b00010_00100_01000_01000_01000_00100_00010;
            7'h29: g = 35'b01000_00100_00010_00010_00010_00100_01000;
            7'h2A: g = 35'b00000_00100_10101_01110_10101_00100_00000;
            7'h2B: g = 35'b00000_00100_00100_11111_00100_00100_00000;
            7'h2C: g = 35'b00000_00000_00000_00000_01100_00100_01000;
            7'h2D: g = 35'b00000_00000_00000_11111_00000_00000_00000;
            7'h2E: g = 35'b00000_00000_00000_00000_00000_01100_01100;
            7'h2F: g = 35'b00000_00001_00010_00100_01000_10000_00000;
            7'h30: g = 35'b01110_10001_10011_10101_11001_10001_01110;
            7'h31: g = 35'b00100_01100_00100_00100_00100_00100_01110;
            7'h32: g = 35'b01110_10001_00001_00010_00100_01000_11111;
            7'h33: g = 35'b11111_00010_00100_00010_00001_10001_01110;
            7'h34: g = 35'b00010_00110_01010_10010_11111_00010_00010;
            7'h35: g = 35'b11111_10000_11110_00001_00001_10001_01110;
            7'h36: g = 35'b00110_01000_10000_11110_10001_10001_01110;
            7'h37: g = 35'b11111_00001_00010_00100_01000_01000_01000;
            7'h38: g = 35'b01110_10001_10001_01110_10001_10001_01110;
            7'h39: g = 35'b01110_10001_10001_01111_00001_00010_01100;
            7'h3A: g = 35'b00000_01100_01100_00000_01100_01100_00000;
            7'h3B: g = 35'b00000_01100_01100_00000_01100_00100_01000;
            7'h3C: g = 35'b00010_00100_01000_10000_01000_00100_00010;
            7'h3D: g = 35'b00000_00000_11111_00000_11111_00000_00000;
            7'h3E: g = 35'b01000_00100_00010_00001_00010_00100_01000;
            7'h3F: g = 35'b01110_10001_00001_00010_00100_00000_00100;
            7'h40: g = 35'b01110_10001_00001_01101_10101_10101_01110;
            7'h41: g = 35'b01110_10001_10001_11111_10001_10001_10001;
            7'h42: g = 35'b11110_10001_10001_11110_10001_10001_11110;
            7'h43: g = 35'b01110_10001_10000_10000_10000_10001_01110;
            7'h44: g = 35'b11100_10010_10001_10001_10001_10010_11100;
            7'h45: g = 35'b11111_10000_10000_11110_10000_10000_11111;
            7'h46: g = 35'b11111_10000_10000_11110_10000_10000_10000;
            7'h47: g = 35'b01110_10001_10000_10111_10001_10001_01111;
            7'h48: g = 35'b10001_10001_10001_11111_10001_10001_10001;
            7'h49: g = 35'b01110_00100_00100_00100_00100_00100_01110;
            7'h4A: g = 35'b00111_00010_00010_00010_00010_10010_01100;
            7'h4B: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            7'h4C: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            7'h4D: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            7'h4E: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            7'h4F: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            7'h50: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            7'h51: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            7'h52: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            7'h53: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            7'h54: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            7'h55: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            7'h56: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            7'h57: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            7'h58: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            7'h59: g = 35'b10001_10001_10001_01010_00100_00100_00100;
            7'h5A: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            7'h5B: g = 35'b01110_01000_01000_01000_01000_01000_01110;
            7'h5C: g = 35'b00000_10000_01000_00100_00010_00001_00000;
            7'h5D: g = 35'b01110_00010_00010_00010_00010_00010_01110;
            7'h5E: g = 35'b00100_01010_10001_00000_00000_00000_00000;
            7'h5F: g = 35'b00000_00000_00000_00000_00000_00000_11111;
            default: g = '0;
        endcase
        return g;
    endfunction

    // One 8-pixel row of the 8x16 cell, address {code[6:0], row[3:0]}.
    // The 5x7 master sits in columns 1..5, doubled vertically into rows 1..14.
    // Codes 0x60..0x7E fold onto 0x40..0x5E; control codes and 0x7F are blank.
    function automatic logic [7:0] font_row(input logic [10:0] addr);
        logic [6:0]  code;
        logic [3:0]  row;
        logic [3:0]  row_m1;
        logic [6:0]  idx;
        logic [34:0] g;
        logic [4:0]  bits;
        int          sel;
        code   = addr[10:4];
        row    = addr[3:0];
        row_m1 = row - 4'd1;
        idx    = (code >= 7'h60) ? code - 7'h20 : code;
        g      = glyph5x7(idx);
        sel    = 34 - 5 * int'(row_m1[3:1]);
        bits   = g[sel -: 5];
        if (code >= 7'h20 && code != 7'h7F && row != 4'd0 && row != 4'd15)
            return {1'b0, bits, 2'b00};
        return 8'h00;
    endfunction

endpackage

// File: rtl/dbg_text_renderer_if.sv
// Video-in / video-out / character-source bundle of the text overlay renderer.
interface dbg_text_renderer_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic [23:0] rgb_in;
    logic        overlay_en;
    logic [6:0]  x;
    logic [4:0]  y;
    logic [7:0]  chr;
    logic [23:0] rgb_out;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;

    // Timing generator / character source side.
    modport master (
        output h_cnt, v_cnt, de_in, hs_in, vs_in, rgb_in, overlay_en, chr,
        input  x, y, rgb_out, hs_out, vs_out, de_out
    );

    // Renderer side.
    modport slave (
        input  h_cnt, v_cnt, de_in, hs_in, vs_in, rgb_in, overlay_en, chr,
        output x, y, rgb_out, hs_out, vs_out, de_out
    );
endinterface

// File: rtl/dbg_font_rom.sv
// 8x16 glyph ROM, 128 codes x 16 rows, registered read, no reset.
module dbg_font_rom
    import dbg_text_renderer_pkg::*;
(
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    // One-cycle synchronous lookup of a glyph row.
    always_ff @(posedge clk) begin
        data <= font_row(addr);
    end

endmodule

// File: rtl/dbg_text_renderer.sv
// Debug text overlay: beam counters -> cell coordinates -> glyph -> composite,
// three pipeline stages with the syncs delayed alongside the pixel.
module dbg_text_renderer
    import dbg_text_renderer_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = DEF_FG,
    parameter logic [23:0] BG_COLOR = DEF_BG
) (
    input logic                 clk,
    input logic                 rst,
    dbg_text_renderer_if.slave  bus
);

    // Stage 1
    logic [7:0]  chr1;
    logic [3:0]  r1;
    logic [2:0]  c1;
    logic [23:0] rgb1;
    sideband_t   sb1;
    logic        ov1;
    // Stage 2
    logic [2:0]  c2;
    logic        inv2;
    logic        transp2;
    logic [23:0] rgb2;
    sideband_t   sb2;
    logic        ov2;
    logic [7:0]  font_data;
    // Stage 3
    logic        pix_bit;
    logic [23:0] pix_rgb;
    logic [23:0] rgb3;
    sideband_t   sb3;

    // v_cnt never exceeds 524, so bit 9 only matters for de, which arrives separately.
    logic unused_v_msb;
    assign unused_v_msb = bus.v_cnt[9];

    // Outside the active area point the character source at the always-blank
    // row so columns 80..99 and the v_cnt=512 wrap never hit real cells.
    always_comb begin
        bus.x = '0;
        bus.y = BLANK_ROW;
        if (bus.de_in) begin
            bus.x = bus.h_cnt[9:3];
            bus.y = bus.v_cnt[8:4];
        end
    end

    // Stage 1: capture the returned code and everything needed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chr1 <= '0;
            r1   <= '0;
            c1   <= '0;
            rgb1 <= '0;
            sb1  <= '0;
            ov1  <= 1'b0;
        end else begin
            chr1 <= bus.chr;
            r1   <= bus.v_cnt[3:0];
            c1   <= bus.h_cnt[2:0];
            rgb1 <= bus.rgb_in;
            sb1  <= '{de: bus.de_in, hs: bus.hs_in, vs: bus.vs_in};
            ov1  <= bus.overlay_en;
        end
    end

    dbg_font_rom u_font_rom (
        .clk  (clk),
        .addr ({chr1[6:0], r1}),
        .data (font_data)
    );

    // Stage 2: forward alongside the ROM read; code 0 marks a see-through cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c2      <= '0;
            inv2    <= 1'b0;
            transp2 <= 1'b0;
            rgb2    <= '0;
            sb2     <= '0;
            ov2     <= 1'b0;
        end else begin
            c2      <= c1;
            inv2    <= chr1[7];
            transp2 <= (chr1 == 8'h00);
            rgb2    <= rgb1;
            sb2     <= sb1;
            ov2     <= ov1;
        end
    end

    // Pick the pixel out of the glyph row (MSB leftmost), apply inverse video,
    // then choose between blank, game video and overlay colours.
    always_comb begin
        pix_bit = font_data[3'd7 - c2] ^ inv2;
        pix_rgb = '0;
        if (sb2.de) begin
            if (!ov2 || transp2)
                pix_rgb = rgb2;
            else
                pix_rgb = pix_bit ? FG_COLOR : BG_COLOR;
        end
    end

    // Stage 3: registered composite and sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb3 <= '0;
            sb3  <= '0;
        end else begin
            rgb3 <= pix_rgb;
            sb3  <= sb2;
        end
    end

    assign bus.rgb_out = rgb3;
    assign bus.hs_out  = sb3.hs;
    assign bus.vs_out  = sb3.vs;
    assign bus.de_out  = sb3.de;

endmodule
